// File: rtl/caf_pkg.sv
// Shared definitions for the CAF complex datapath: multiply mode encoding and
// width helpers used by both the RTL and the testbench.
package caf_pkg;

    typedef enum logic {
        MODE_MUL  = 1'b0,
        MODE_CONJ = 1'b1
    } cmult_mode_e;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    function automatic int prod_bits(input int x_bits, input int y_bits);
        return x_bits + y_bits + 1;
    endfunction

    function automatic int sum_bits(input int x_bits, input int y_bits, input int length);
        return prod_bits(x_bits, y_bits) + clog2(length);
    endfunction

endpackage

// File: rtl/cmult_pip.sv
// Two-stage pipelined complex multiplier: four real products, then the
// complex combine for x*y or x*conj(y). Valid, last and mode ride alongside.
module cmult_pip
    import caf_pkg::*;
#(
    parameter int X_BITS    = 8,
    parameter int Y_BITS    = 8,
    parameter int PROD_BITS = prod_bits(X_BITS, Y_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic                 in_mode,
    input  logic [X_BITS-1:0]    xi,
    input  logic [X_BITS-1:0]    xq,
    input  logic [Y_BITS-1:0]    yi,
    input  logic [Y_BITS-1:0]    yq,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 out_mode,
    output logic [PROD_BITS-1:0] re,
    output logic [PROD_BITS-1:0] im
);

    localparam int RAW_BITS = X_BITS + Y_BITS;

    logic                        s2_valid;
    logic                        s2_last;
    logic                        s2_mode;
    logic signed [RAW_BITS-1:0]  p_ii;
    logic signed [RAW_BITS-1:0]  p_qq;
    logic signed [RAW_BITS-1:0]  p_qi;
    logic signed [RAW_BITS-1:0]  p_iq;
    logic signed [PROD_BITS-1:0] ext_ii;
    logic signed [PROD_BITS-1:0] ext_qq;
    logic signed [PROD_BITS-1:0] ext_qi;
    logic signed [PROD_BITS-1:0] ext_iq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_mode  <= 1'b0;
            p_ii     <= '0;
            p_qq     <= '0;
            p_qi     <= '0;
            p_iq     <= '0;
        end else if (en) begin
            s2_valid <= in_valid;
            s2_last  <= in_last;
            s2_mode  <= in_mode;
            p_ii     <= RAW_BITS'($signed(xi)) * RAW_BITS'($signed(yi));
            p_qq     <= RAW_BITS'($signed(xq)) * RAW_BITS'($signed(yq));
            p_qi     <= RAW_BITS'($signed(xq)) * RAW_BITS'($signed(yi));
            p_iq     <= RAW_BITS'($signed(xi)) * RAW_BITS'($signed(yq));
        end
    end

    // One guard bit so the sum/difference of two full-range products cannot wrap.
    assign ext_ii = PROD_BITS'(p_ii);
    assign ext_qq = PROD_BITS'(p_qq);
    assign ext_qi = PROD_BITS'(p_qi);
    assign ext_iq = PROD_BITS'(p_iq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_mode  <= 1'b0;
            re        <= '0;
            im        <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_last  <= s2_last;
            out_mode  <= s2_mode;
            if (s2_mode == MODE_CONJ) begin
                re <= ext_ii + ext_qq;
                im <= ext_qi - ext_iq;
            end else begin
                re <= ext_ii - ext_qq;
                im <= ext_qi + ext_iq;
            end
        end
    end

endmodule

// File: rtl/cmac_acc_pip.sv
// Pipelined complex multiply-accumulate: joins the x/y streams, counts LENGTH
// pairs per frame and emits one backpressured complex sum per frame.
module cmac_acc_pip
    import caf_pkg::*;
#(
    parameter int X_BITS    = 8,
    parameter int Y_BITS    = 8,
    parameter int LENGTH    = 4,
    parameter int PROD_BITS = prod_bits(X_BITS, Y_BITS),
    parameter int SUM_BITS  = sum_bits(X_BITS, Y_BITS, LENGTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_axis_x_tvalid,
    output logic                m_axis_x_tready,
    input  logic [X_BITS-1:0]   xi,
    input  logic [X_BITS-1:0]   xq,
    input  logic                m_axis_y_tvalid,
    output logic                m_axis_y_tready,
    input  logic [Y_BITS-1:0]   yi,
    input  logic [Y_BITS-1:0]   yq,
    input  logic                conj_y,
    input  logic                m_axis_product_tready,
    output logic                s_axis_product_tvalid,
    output logic [SUM_BITS-1:0] i,
    output logic [SUM_BITS-1:0] q
);

    localparam int CNT_BITS = (LENGTH > 1) ? clog2(LENGTH) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(LENGTH - 1);

    logic                        stall;
    logic                        ready;
    logic                        enable;
    logic                        accept;
    logic                        pair_last;
    logic                        pair_mode;
    logic [CNT_BITS-1:0]         cnt;
    logic                        mode_latched;

    logic                        s1_valid;
    logic                        s1_last;
    logic                        s1_mode;
    logic [X_BITS-1:0]           s1_xi;
    logic [X_BITS-1:0]           s1_xq;
    logic [Y_BITS-1:0]           s1_yi;
    logic [Y_BITS-1:0]           s1_yq;

    logic                        s3_valid;
    logic                        s3_last;
    logic                        s3_mode;
    logic [PROD_BITS-1:0]        s3_re;
    logic [PROD_BITS-1:0]        s3_im;

    logic signed [SUM_BITS-1:0]  acc_i;
    logic signed [SUM_BITS-1:0]  acc_q;
    logic signed [SUM_BITS-1:0]  sum_i;
    logic signed [SUM_BITS-1:0]  sum_q;
    logic                        load_result;

    // Only a finished frame waiting behind an unconsumed result blocks the pipe.
    assign stall  = s_axis_product_tvalid & ~m_axis_product_tready & s3_valid & s3_last;
    assign ready  = ~reset & ~stall;
    assign enable = ~stall;
    assign m_axis_x_tready = ready;
    assign m_axis_y_tready = ready;

    assign accept    = m_axis_x_tvalid & m_axis_y_tvalid & ready;
    assign pair_last = (cnt == LAST_CNT);
    assign pair_mode = (cnt == '0) ? conj_y : mode_latched;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            mode_latched <= 1'b0;
        end else if (accept) begin
            cnt <= pair_last ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
                mode_latched <= conj_y;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_xi    <= '0;
            s1_xq    <= '0;
            s1_yi    <= '0;
            s1_yq    <= '0;
        end else if (enable) begin
            s1_valid <= accept;
            s1_last  <= pair_last;
            s1_mode  <= pair_mode;
            s1_xi    <= xi;
            s1_xq    <= xq;
            s1_yi    <= yi;
            s1_yq    <= yq;
        end
    end

    cmult_pip #(
        .X_BITS    (X_BITS),
        .Y_BITS    (Y_BITS),
        .PROD_BITS (PROD_BITS)
    ) u_cmult (
        .clk       (clk),
        .reset     (reset),
        .en        (enable),
        .in_valid  (s1_valid),
        .in_last   (s1_last),
        .in_mode   (s1_mode),
        .xi        (s1_xi),
        .xq        (s1_xq),
        .yi        (s1_yi),
        .yq        (s1_yq),
        .out_valid (s3_valid),
        .out_last  (s3_last),
        .out_mode  (s3_mode),
        .re        (s3_re),
        .im        (s3_im)
    );

    assign sum_i       = acc_i + SUM_BITS'($signed(s3_re));
    assign sum_q       = acc_q + SUM_BITS'($signed(s3_im));
    assign load_result = s3_valid & s3_last & enable;

    // A last product closes the frame: the result register takes acc+product and
    // the accumulator restarts at zero so the next frame follows without a gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_i                 <= '0;
            acc_q                 <= '0;
            i                     <= '0;
            q                     <= '0;
            s_axis_product_tvalid <= 1'b0;
        end else begin
            if (s3_valid && enable) begin
                if (s3_last) begin
                    i     <= sum_i;
                    q     <= sum_q;
                    acc_i <= '0;
                    acc_q <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
            if (load_result) begin
                s_axis_product_tvalid <= 1'b1;
            end else if (m_axis_product_tready) begin
                s_axis_product_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmac_acc_pip.sv
// Testbench for cmac_acc_pip: directed frame table, backpressure, gapped
// valids and reset sequences, then random traffic against a complex-arithmetic model.
module tb_cmac_acc_pip;
    import caf_pkg::*;

    localparam int X_BITS    = 8;
    localparam int Y_BITS    = 8;
    localparam int LENGTH    = 4;
    localparam int PROD_BITS = prod_bits(X_BITS, Y_BITS);
    localparam int SUM_BITS  = sum_bits(X_BITS, Y_BITS, LENGTH);

    logic                clk;
    logic                reset;
    logic                m_axis_x_tvalid;
    logic                m_axis_x_tready;
    logic [X_BITS-1:0]   xi;
    logic [X_BITS-1:0]   xq;
    logic                m_axis_y_tvalid;
    logic                m_axis_y_tready;
    logic [Y_BITS-1:0]   yi;
    logic [Y_BITS-1:0]   yq;
    logic                conj_y;
    logic                m_axis_product_tready;
    logic                s_axis_product_tvalid;
    logic [SUM_BITS-1:0] i;
    logic [SUM_BITS-1:0] q;

    cmac_acc_pip #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS),
        .LENGTH (LENGTH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .m_axis_x_tvalid       (m_axis_x_tvalid),
        .m_axis_x_tready       (m_axis_x_tready),
        .xi                    (xi),
        .xq                    (xq),
        .m_axis_y_tvalid       (m_axis_y_tvalid),
        .m_axis_y_tready       (m_axis_y_tready),
        .yi                    (yi),
        .yq                    (yq),
        .conj_y                (conj_y),
        .m_axis_product_tready (m_axis_product_tready),
        .s_axis_product_tvalid (s_axis_product_tvalid),
        .i                     (i),
        .q                     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   xi;
        int   xq;
        int   yi;
        int   yq;
        logic conj;
        logic toggle;
        int   exp_i;
        int   exp_q;
    } vec_t;

    vec_t vecs[4];

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_i_q[$];
    int   exp_q_q[$];
    int   m_cnt = 0;
    logic m_conj = 1'b0;
    int   m_acc_i = 0;
    int   m_acc_q = 0;
    int   delivered = 0;
    logic held = 1'b0;
    int   held_i = 0;
    int   held_q = 0;
    logic last_accept = 1'b0;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors = vectors + 1;
        if (actual != expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: accepted pairs form frames of LENGTH complex products
    // computed with plain integer arithmetic; finished frames queue up as results.
    task automatic observe();
        int ax, bx, ay, by;
        last_accept = 1'b0;
        if (reset) begin
            exp_i_q.delete();
            exp_q_q.delete();
            m_cnt   = 0;
            m_acc_i = 0;
            m_acc_q = 0;
            held    = 1'b0;
            return;
        end
        if (s_axis_product_tvalid && !m_axis_product_tready) begin
            if (held) begin
                check_output("held_i", int'($signed(i)), held_i);
                check_output("held_q", int'($signed(q)), held_q);
            end
            held   = 1'b1;
            held_i = int'($signed(i));
            held_q = int'($signed(q));
        end else begin
            held = 1'b0;
        end
        if (s_axis_product_tvalid && m_axis_product_tready) begin
            if (exp_i_q.size() == 0) begin
                check_output("unexpected_result", 1, 0);
            end else begin
                check_output("result_i", int'($signed(i)), exp_i_q.pop_front());
                check_output("result_q", int'($signed(q)), exp_q_q.pop_front());
                delivered = delivered + 1;
            end
        end
        if (m_axis_x_tvalid && m_axis_y_tvalid && m_axis_x_tready) begin
            last_accept = 1'b1;
            if (m_cnt == 0) m_conj = conj_y;
            ax = int'($signed(xi));
            bx = int'($signed(xq));
            ay = int'($signed(yi));
            by = m_conj ? -int'($signed(yq)) : int'($signed(yq));
            m_acc_i = m_acc_i + ax * ay - bx * by;
            m_acc_q = m_acc_q + ax * by + bx * ay;
            m_cnt = m_cnt + 1;
            if (m_cnt == LENGTH) begin
                exp_i_q.push_back(m_acc_i);
                exp_q_q.push_back(m_acc_q);
                m_cnt   = 0;
                m_acc_i = 0;
                m_acc_q = 0;
            end
        end
    endtask

    task automatic step();
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int a, input int b, input int c, input int d, input logic cj);
        xi = X_BITS'(a);
        xq = X_BITS'(b);
        yi = Y_BITS'(c);
        yq = Y_BITS'(d);
        conj_y = cj;
        m_axis_x_tvalid = 1'b1;
        m_axis_y_tvalid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            if (last_accept) break;
        end
        if (!last_accept) check_output("accept_timeout", 0, 1);
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        conj_y = 1'b0;
        m_axis_product_tready = 1'b0;

        vecs[0] = '{1, 2, 3, 4, 1'b0, 1'b0, -20, 40};
        vecs[1] = '{1, 2, 3, 4, 1'b1, 1'b0, 44, 8};
        vecs[2] = '{1, 2, 3, 4, 1'b1, 1'b1, 44, 8};
        vecs[3] = '{-128, -128, -128, -128, 1'b0, 1'b0, 0, 131072};

        @(negedge clk);
        #1;
        check_output("reset_x_tready", int'(m_axis_x_tready), 0);
        check_output("reset_y_tready", int'(m_axis_y_tready), 0);
        check_output("reset_tvalid", int'(s_axis_product_tvalid), 0);
        check_output("reset_i", int'($signed(i)), 0);
        check_output("reset_q", int'($signed(q)), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed frames: result held by backpressure so latency can be pinned.
        for (int v = 0; v < 4; v++) begin
            m_axis_product_tready = 1'b0;
            for (int p = 0; p < LENGTH; p++) begin
                apply_stimulus(vecs[v].xi, vecs[v].xq, vecs[v].yi, vecs[v].yq,
                               vecs[v].conj ^ (vecs[v].toggle && p > 0));
            end
            step();
            step();
            check_output("latency_early", int'(s_axis_product_tvalid), 0);
            step();
            check_output("latency_valid", int'(s_axis_product_tvalid), 1);
            check_output("table_i", int'($signed(i)), vecs[v].exp_i);
            check_output("table_q", int'($signed(q)), vecs[v].exp_q);
            m_axis_product_tready = 1'b1;
            step();
            check_output("table_drained", int'(s_axis_product_tvalid), 0);
        end

        // Two frames against a blocked consumer: stall only when 2nd last hits S3.
        base = delivered;
        m_axis_product_tready = 1'b0;
        for (int p = 0; p < 2 * LENGTH; p++) apply_stimulus(1, 2, 3, 4, 1'b0);
        check_output("bp_ready_e8", int'(m_axis_x_tready), 1);
        step();
        check_output("bp_ready_e9", int'(m_axis_x_tready), 1);
        step();
        check_output("bp_ready_e10", int'(m_axis_x_tready), 0);
        step();
        step();
        check_output("bp_ready_hold", int'(m_axis_y_tready), 0);
        check_output("bp_held_i", int'($signed(i)), -20);
        m_axis_product_tready = 1'b1;
        step();
        check_output("bp_back_to_back", int'(s_axis_product_tvalid), 1);
        step();
        step();
        check_output("bp_delivered", delivered - base, 2);
        check_output("bp_idle", int'(s_axis_product_tvalid), 0);

        // x valid on odd cycles only, y always valid.
        base = delivered;
        xi = 8'd1; xq = 8'd2; yi = 8'd3; yq = 8'd4;
        conj_y = 1'b0;
        for (int c = 0; c < 4 * LENGTH; c++) begin
            m_axis_x_tvalid = (c % 2) == 1;
            m_axis_y_tvalid = 1'b1;
            step();
        end
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check_output("gap_delivered", delivered - base, 2);

        // Reset in the middle of a frame discards the partial sum.
        apply_stimulus(1, 2, 3, 4, 1'b0);
        apply_stimulus(1, 2, 3, 4, 1'b0);
        reset = 1'b1;
        #1;
        check_output("midreset_tready", int'(m_axis_x_tready), 0);
        check_output("midreset_tvalid", int'(s_axis_product_tvalid), 0);
        check_output("midreset_i", int'($signed(i)), 0);
        check_output("midreset_q", int'($signed(q)), 0);
        step();
        reset = 1'b0;
        base = delivered;
        for (int p = 0; p < LENGTH; p++) apply_stimulus(1, 2, 3, 4, 1'b0);
        for (int c = 0; c < 5; c++) step();
        check_output("postreset_delivered", delivered - base, 1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            m_axis_x_tvalid = 1'($urandom_range(0, 3) != 0);
            m_axis_y_tvalid = 1'($urandom_range(0, 3) != 0);
            m_axis_product_tready = 1'($urandom_range(0, 3) != 0);
            xi = X_BITS'($urandom);
            xq = X_BITS'($urandom);
            yi = Y_BITS'($urandom);
            yq = Y_BITS'($urandom);
            conj_y = 1'($urandom_range(0, 1));
            step();
        end
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        m_axis_product_tready = 1'b1;
        for (int k = 0; k < LENGTH && m_cnt != 0; k++) begin
            apply_stimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 8; c++) step();
        check_output("random_queue_empty", exp_i_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmac_acc_pip.md
# cmac_acc_pip

Pipelined complex multiply-accumulate engine for the CAF datapath. It is the parametrised successor to the fixed-length pipelined dot product. It consumes paired complex samples x and y over a joined valid/ready handshake and forms either x·y or x·conj(y), selected per frame. It accumulates LENGTH products per frame and emits one complex sum per frame on a backpressured output stream, with no gap between frames.

## Interface
Parameters:
- X_BITS, 8: width of xi and xq, signed two's complement.
- Y_BITS, 8: width of yi and yq, signed two's complement.
- LENGTH, 4: products per frame; must be ≥ 1.
- PROD_BITS, X_BITS+Y_BITS+1: width of one complex product component (derived).
- SUM_BITS, PROD_BITS+$clog2(LENGTH): width of the output component (derived).

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-high.
- m_axis_x_tvalid, in, 1: x sample valid.
- m_axis_x_tready, out, 1: x sample accepted this cycle if valid.
- xi / xq, in, X_BITS each: x in-phase / quadrature.
- m_axis_y_tvalid, in, 1: y sample valid.
- m_axis_y_tready, out, 1: y sample accepted this cycle if valid.
- yi / yq, in, Y_BITS each: y in-phase / quadrature.
- conj_y, in, 1: 0 selects x·y, 1 selects x·conj(y). Sampled with the first pair of each frame.
- m_axis_product_tready, in, 1: downstream accepts the result.
- s_axis_product_tvalid, out, 1: result valid.
- i / q, out, SUM_BITS each: accumulated sum, in-phase / quadrature.

## Operation
- A pair is accepted on an edge where m_axis_x_tvalid, m_axis_y_tvalid and ready are all 1. Ready is !stall and is 0 during reset.
- Both tready outputs are identical and always driven from the same ready signal.
- A lone valid (x without y, or y without x) is not consumed. The producer holds it until its partner arrives.
- Frame counter counts accepted pairs 0..LENGTH-1 and wraps to 0 after the last pair. The pair at count LENGTH-1 carries a last tag.
- conj_y is latched at count 0 and travels with every pair of that frame. Changes to conj_y mid-frame are ignored.
- Pipeline stages, each carrying valid, last and mode:
  - S1: registered inputs.
  - S2: four real products. Owned by cmult_pip.
  - S3: complex product, re = xi·yi ∓ xq·yq, im = xq·yi ± xi·yq (upper sign for conj_y=0). Sign-extended to PROD_BITS.
  - S4: accumulator, sign-extended to SUM_BITS. A valid non-last product adds into the accumulator.
- A valid last product loads acc+product into the i/q output register, clears the accumulator to 0, and sets s_axis_product_tvalid.
- Bubbles (valid=0) pass through without touching the accumulator.
- No saturation is needed. SUM_BITS is sized so overflow cannot occur.
- Output handshake: s_axis_product_tvalid clears on the edge where m_axis_product_tready=1, unless a new result loads on that same edge, in which case it stays 1.
- i and q are held stable while tvalid=1 and tready=0.
- stall = s_axis_product_tvalid & !m_axis_product_tready & S3.valid & S3.last. While stall=1, every stage register and the frame counter freeze.
- Non-last products never stall. The next frame accumulates while the previous result waits.
- Reset values: all stage valids 0, accumulator 0, counter 0, latched mode 0, i=q=0, s_axis_product_tvalid=0, both treadys 0.
- Reset asserted mid-frame discards the partial sum and any pending result.

## Timing
- Latency: for the last pair accepted at edge E, s_axis_product_tvalid is 1 after edge E+3 when there is no stall.
- Throughput: one pair per clk sustained, one result per LENGTH clk.
- LENGTH=1: every pair is last, and each output equals the single product.
- Ready depends combinationally on m_axis_product_tready through stall. There is no combinational path from tvalid inputs to tready.
- A result is cleared and a new result loaded on the same edge back-to-back with no gap.

## Structure
- Shared package caf_pkg:
  - clog2 helper.
  - Width functions for PROD_BITS and SUM_BITS, shared with the testbench generator.
- One sub-module, cmult_pip, containing stages S2–S3. It takes a mode and an enable (!stall) input, and passes through valid, last and mode.
- Top level holds the handshake, frame counter, accumulator and output register.

## Test plan
Use X_BITS=Y_BITS=8 and LENGTH=4 unless stated otherwise.
- x=(1,2), y=(3,4), conj_y=0, 4 back-to-back pairs: one result i=-20, q=40, tvalid 1 after edge E+3 of the 4th accept.
- Same data with conj_y=1: i=44, q=8. Toggling conj_y mid-frame leaves the result unchanged.
- x=y=(-128,-128), conj_y=0, 4 pairs: i=0, q=131072, no overflow.
- m_axis_product_tready held 0, 8 pairs streamed: the first result is held stable, and tready drops only when the 8th product reaches S3. Releasing tready delivers (-20,40) twice in order, with no pair lost or duplicated.
- m_axis_x_tvalid on odd cycles only, y always valid: the pair count advances only on joint valid, and the result is still (-20,40).
- reset pulse after 2 accepted pairs, then 4 fresh pairs: all outputs 0 during reset, and the next result is (-20,40).
